mem_req_initiator: RTL

//  Initiator side of the data-memory stall handshake (addr/write_data/memwrite/memread/sign_mask out,
//  clk_stall/read_data in). Accepts load/store requests from the core over valid/ready, queues them,

---
 rtl/mem_if_pkg.sv | 52 +++++
 rtl/mem_req_fifo.sv | 47 ++++
 rtl/mem_req_initiator.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared types for the data-memory request initiator: size codes, sign_mask encodings, FSM states.
// Build option MEM_MISALIGN_CHECK_EN turns misaligned half/word requests into error responses.
package mem_if_pkg;

  localparam logic [2:0] SM_BYTE = 3'b001;
  localparam logic [2:0] SM_HALF = 3'b011;
  localparam logic [2:0] SM_WORD = 3'b111;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
  } req_t;

  // Stores never ask for sign extension, so bit3 is forced low for them.
  function automatic logic [3:0] sign_mask(input req_t r);
    logic [2:0] m;
    case (r.size)
      SZ_BYTE: m = SM_BYTE;
      SZ_HALF: m = SM_HALF;
      default: m = SM_WORD;
    endcase
    return {r.sgn & ~r.we, m};
  endfunction

  // Requests that complete with resp_err and never reach the memory.
  function automatic logic req_bad(input req_t r);
    logic bad;
    bad = (r.size == SZ_ILL);
`ifdef MEM_MISALIGN_CHECK_EN
    bad = bad | ((r.size == SZ_HALF) && r.addr[0])
              | ((r.size == SZ_WORD) && (r.addr[1:0] != 2'b00));
`endif
    return bad;
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Request queue for mem_req_initiator: DEPTH entries (power of 2), wrapping pointers, full/empty.
module mem_req_fifo
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  req_t i_din,
  input  logic i_pop,
  output req_t o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_t          r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + AW'(1);
      if (i_pop)  r_rp <= r_rp + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rp];
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/mem_req_initiator.sv
// Core-side initiator for the data-memory clk_stall handshake: queues requests, strobes memory once,
// follows clk_stall rise/fall with a timeout, returns one response per request. Option: MEM_MISALIGN_CHECK_EN.
module mem_req_initiator
  import mem_if_pkg::*;
#(
  parameter int REQ_DEPTH   = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic        mem_clk_stall,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t        r_state, w_next;
  req_t          w_din, w_head;
  logic          w_full, w_empty, w_push, w_pop, w_bad, w_to;
  logic [CW-1:0] r_cnt;
  logic          r_we, r_err;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic [3:0]    r_mask;

  assign w_din  = '{we: req_we, addr: req_addr, wdata: req_wdata, size: req_size, sgn: req_signed};
  assign w_push = req_valid && !w_full;
  assign w_bad  = req_bad(w_head);
  assign w_to   = (r_cnt == CW'(TIMEOUT_CYC - 1));

  mem_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_din  (w_din),
    .i_pop  (w_pop),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      ST_IDLE: if (!w_empty) begin
        w_pop  = 1'b1;
        w_next = w_bad ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE:   w_next = ST_WAIT_HI;
      ST_WAIT_HI: if (mem_clk_stall) w_next = ST_WAIT_LO;
                  else if (w_to)     w_next = ST_RESP;
      ST_WAIT_LO: if (!mem_clk_stall || w_to) w_next = ST_RESP;
      ST_RESP:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_next;
      // Counter restarts whenever the state changes, so each wait state gets its own budget.
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state == ST_WAIT_HI || r_state == ST_WAIT_LO) r_cnt <= r_cnt + CW'(1);
      case (r_state)
        ST_IDLE: if (!w_empty) begin
          r_err   <= w_bad;
          r_rdata <= '0;
          if (!w_bad) begin
            r_we    <= w_head.we;
            r_addr  <= w_head.addr;
            r_wdata <= w_head.wdata;
            r_mask  <= sign_mask(w_head);
          end
        end
        ST_WAIT_HI: if (!mem_clk_stall && w_to) r_err <= 1'b1;
        ST_WAIT_LO: begin
          if (!mem_clk_stall)  r_rdata <= r_we ? '0 : mem_rdata;
          else if (w_to)       r_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so they exist for exactly the ISSUE cycle and die with reset.
  assign mem_memread   = (r_state == ST_ISSUE) && !r_we;
  assign mem_memwrite  = (r_state == ST_ISSUE) &&  r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign mem_sign_mask = r_mask;
  assign req_ready     = !w_full;
  assign resp_valid    = (r_state == ST_RESP);
  assign resp_err      = resp_valid && r_err;
  assign resp_rdata    = r_rdata;

endmodule
